cluster_header_seq: RTL and testbench



---
 rtl/cluster_header_seq.sv | 98 +++++++++
 tb/tb_cluster_header_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cluster_header_seq.sv
// cluster_header_seq: per-cluster clock-enable sync plus staggered reset/debug-init release sequencer
module cluster_header_seq #(
  parameter int NUM_CL    = 4,
  parameter int STAGGER   = 8,
  parameter int CKEN_SYNC = 2,
  parameter int DBG_HOLD  = 16
) (
  input  logic              gclk,
  input  logic              grst,
  input  logic [NUM_CL-1:0] cluster_cken,
  input  logic              gdbginit_req,
  output logic [NUM_CL-1:0] rclk_en,
  output logic [NUM_CL-1:0] cluster_grst_l,
  output logic [NUM_CL-1:0] dbginit_l,
  output logic              seq_busy,
  output logic [1:0]        seq_state
);
  localparam int MX = STAGGER > DBG_HOLD ? STAGGER : DBG_HOLD;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam int IW = NUM_CL > 1 ? $clog2(NUM_CL) : 1;
  typedef enum logic [1:0] {S_RST, S_REL, S_RUN, S_DBG} state_e;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              mode_q, mode_d;
  logic [NUM_CL-1:0] grst_l_q, grst_l_d, dbg_l_q, dbg_l_d;
  logic [NUM_CL-1:0] sync_q [CKEN_SYNC];
  logic [NUM_CL-1:0] sync_d [CKEN_SYNC];
  logic              rel;

  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q  <= S_RST;
      cnt_q    <= '0;
      idx_q    <= '0;
      mode_q   <= 1'b0;
      grst_l_q <= '0;
      dbg_l_q  <= '0;
      for (int i = 0; i < CKEN_SYNC; i++) sync_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      grst_l_q <= grst_l_d;
      dbg_l_q  <= dbg_l_d;
      sync_q   <= sync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    case (state_q)
      S_RST: begin
        state_d = S_REL;
        cnt_d   = CW'(STAGGER - 1);
        idx_d   = '0;
      end
      S_REL: begin
        cnt_d   = cnt_q == '0 ? CW'(STAGGER - 1) : cnt_q - 1'b1;
        state_d = cnt_q == '0 && idx_q == IW'(NUM_CL - 1) ? S_RUN : S_REL;
        idx_d   = cnt_q == '0 && idx_q != IW'(NUM_CL - 1) ? idx_q + 1'b1 : idx_q;
      end
      S_RUN: begin
        state_d = gdbginit_req ? S_DBG : S_RUN;
        cnt_d   = gdbginit_req ? CW'(DBG_HOLD - 1) : cnt_q;
        mode_d  = gdbginit_req ? 1'b1 : mode_q;
      end
      default: begin
        state_d = cnt_q == '0 ? S_REL : S_DBG;
        cnt_d   = cnt_q == '0 ? CW'(STAGGER - 1) : cnt_q - 1'b1;
        idx_d   = cnt_q == '0 ? '0 : idx_q;
      end
    endcase
  end

  // mode_q=1 marks a debug-only re-sequence, which must leave cluster reset released
  always_comb begin
    rel      = state_q == S_REL && cnt_q == '0;
    grst_l_d = grst_l_q;
    dbg_l_d  = (state_q == S_RUN && gdbginit_req) ? '0 : dbg_l_q;
    for (int k = 0; k < NUM_CL; k++) begin
      dbg_l_d[k]  = (rel && idx_q == IW'(k)) ? 1'b1 : dbg_l_d[k];
      grst_l_d[k] = (rel && !mode_q && idx_q == IW'(k)) ? 1'b1 : grst_l_q[k];
    end
    sync_d[0] = cluster_cken;
    for (int i = 1; i < CKEN_SYNC; i++) sync_d[i] = sync_q[i-1];
  end

  assign rclk_en        = sync_q[CKEN_SYNC-1];
  assign cluster_grst_l = grst_l_q;
  assign dbginit_l      = dbg_l_q;
  assign seq_busy       = state_q != S_RUN;
  assign seq_state      = state_q;
endmodule

// File: tb/tb_cluster_header_seq.sv
// tb_cluster_header_seq: directed checks of the cluster header sequencer, default and minimal configs
module tb_cluster_header_seq;
  logic       gclk = 1'b0;
  logic       grst = 1'b1;
  logic [3:0] cluster_cken = '0;
  logic       gdbginit_req = 1'b0;
  logic [3:0] rclk_en, cluster_grst_l, dbginit_l;
  logic       seq_busy;
  logic [1:0] seq_state;
  logic       g2rst = 1'b1;
  logic [0:0] cken2 = '0;
  logic       req2 = 1'b0;
  logic [0:0] rclk2, grst2_l, dbg2_l;
  logic       busy2;
  logic [1:0] state2;
  int pass_cnt = 0;
  int total = 0;

  always #5 gclk = ~gclk;

  cluster_header_seq dut (
    .gclk(gclk), .grst(grst), .cluster_cken(cluster_cken), .gdbginit_req(gdbginit_req),
    .rclk_en(rclk_en), .cluster_grst_l(cluster_grst_l), .dbginit_l(dbginit_l),
    .seq_busy(seq_busy), .seq_state(seq_state)
  );

  cluster_header_seq #(.NUM_CL(1), .STAGGER(1), .CKEN_SYNC(2), .DBG_HOLD(1)) dut2 (
    .gclk(gclk), .grst(g2rst), .cluster_cken(cken2), .gdbginit_req(req2),
    .rclk_en(rclk2), .cluster_grst_l(grst2_l), .dbginit_l(dbg2_l),
    .seq_busy(busy2), .seq_state(state2)
  );

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  function automatic logic [3:0] mask(int n);
    return 4'((1 << n) - 1);
  endfunction

  task automatic test_reset();
    grst = 1'b1;
    cluster_cken = 4'b1111;
    repeat (5) step();
    total++; if (rclk_en !== 4'b0000) $display("FAIL reset_rclk got %b want 0000", rclk_en); else pass_cnt++;
    total++; if (cluster_grst_l !== 4'b0000) $display("FAIL reset_grst_l got %b want 0000", cluster_grst_l); else pass_cnt++;
    total++; if (dbginit_l !== 4'b0000) $display("FAIL reset_dbg_l got %b want 0000", dbginit_l); else pass_cnt++;
    total++; if (seq_busy !== 1'b1) $display("FAIL reset_busy got %b want 1", seq_busy); else pass_cnt++;
    total++; if (seq_state !== 2'd0) $display("FAIL reset_state got %0d want 0", seq_state); else pass_cnt++;
    cluster_cken = 4'b0000;
  endtask

  task automatic test_release();
    logic [3:0] m;
    grst = 1'b0;
    step();
    total++; if (seq_state !== 2'd1) $display("FAIL rel_start_state got %0d want 1", seq_state); else pass_cnt++;
    total++; if (cluster_grst_l !== 4'b0000) $display("FAIL rel_start_grst_l got %b want 0000", cluster_grst_l); else pass_cnt++;
    for (int e = 1; e <= 32; e++) begin
      step();
      m = mask(e / 8);
      total++; if (cluster_grst_l !== m) $display("FAIL rel_grst_l e=%0d got %b want %b", e, cluster_grst_l, m); else pass_cnt++;
      total++; if (dbginit_l !== m) $display("FAIL rel_dbg_l e=%0d got %b want %b", e, dbginit_l, m); else pass_cnt++;
      total++; if (seq_busy !== (e < 32)) $display("FAIL rel_busy e=%0d got %b want %b", e, seq_busy, e < 32); else pass_cnt++;
      total++; if (seq_state !== (e < 32 ? 2'd1 : 2'd2)) $display("FAIL rel_state e=%0d got %0d", e, seq_state); else pass_cnt++;
      total++; if (rclk_en !== (e >= 5 ? 4'b0100 : 4'b0000)) $display("FAIL rel_rclk e=%0d got %b", e, rclk_en); else pass_cnt++;
      if (e == 3) cluster_cken = 4'b0100;
    end
  endtask

  task automatic test_cken();
    logic [3:0] v [5] = '{4'b1010, 4'b0101, 4'b1111, 4'b0000, 4'b0110};
    logic [3:0] ex;
    for (int i = 0; i < 6; i++) begin
      cluster_cken = v[i < 5 ? i : 4];
      step();
      ex = i == 0 ? 4'b0100 : v[i-1];
      total++; if (rclk_en !== ex) $display("FAIL cken_sync i=%0d got %b want %b", i, rclk_en, ex); else pass_cnt++;
    end
  endtask

  task automatic dbg_cycle(string tag);
    logic [3:0] m;
    total++; if (dbginit_l !== 4'b0000) $display("FAIL %s_entry_dbg got %b want 0000", tag, dbginit_l); else pass_cnt++;
    total++; if (seq_state !== 2'd3) $display("FAIL %s_entry_state got %0d want 3", tag, seq_state); else pass_cnt++;
    for (int e = 1; e <= 48; e++) begin
      step();
      m = e < 16 ? 4'b0000 : mask((e - 16) / 8);
      total++; if (dbginit_l !== m) $display("FAIL %s_dbg_l e=%0d got %b want %b", tag, e, dbginit_l, m); else pass_cnt++;
      total++; if (cluster_grst_l !== 4'b1111) $display("FAIL %s_grst_l e=%0d got %b want 1111", tag, e, cluster_grst_l); else pass_cnt++;
      total++; if (seq_state !== (e < 16 ? 2'd3 : e < 48 ? 2'd1 : 2'd2)) $display("FAIL %s_state e=%0d got %0d", tag, e, seq_state); else pass_cnt++;
      total++; if (seq_busy !== (e < 48)) $display("FAIL %s_busy e=%0d got %b", tag, e, seq_busy); else pass_cnt++;
    end
  endtask

  task automatic test_dbg_pulse();
    gdbginit_req = 1'b1;
    step();
    gdbginit_req = 1'b0;
    dbg_cycle("dbgp");
  endtask

  task automatic test_dbg_held();
    gdbginit_req = 1'b1;
    step();
    dbg_cycle("dbgh");
    step();
    total++; if (seq_state !== 2'd3) $display("FAIL dbgh_retrig_state got %0d want 3", seq_state); else pass_cnt++;
    total++; if (dbginit_l !== 4'b0000) $display("FAIL dbgh_retrig_dbg got %b want 0000", dbginit_l); else pass_cnt++;
    gdbginit_req = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_grst_mid();
    grst = 1'b1;
    step();
    grst = 1'b0;
    repeat (12) step();
    total++; if (cluster_grst_l !== 4'b0001) $display("FAIL mid_pre_grst_l got %b want 0001", cluster_grst_l); else pass_cnt++;
    total++; if (rclk_en !== 4'b0110) $display("FAIL mid_pre_rclk got %b want 0110", rclk_en); else pass_cnt++;
    grst = 1'b1;
    step();
    total++; if (cluster_grst_l !== 4'b0000) $display("FAIL mid_grst_l got %b want 0000", cluster_grst_l); else pass_cnt++;
    total++; if (dbginit_l !== 4'b0000) $display("FAIL mid_dbg_l got %b want 0000", dbginit_l); else pass_cnt++;
    total++; if (rclk_en !== 4'b0000) $display("FAIL mid_rclk got %b want 0000", rclk_en); else pass_cnt++;
    total++; if (seq_state !== 2'd0 || seq_busy !== 1'b1) $display("FAIL mid_state got %0d/%b want 0/1", seq_state, seq_busy); else pass_cnt++;
    grst = 1'b0;
    step();
    total++; if (seq_state !== 2'd1 || rclk_en !== 4'b0000) $display("FAIL mid_restart got %0d/%b want 1/0000", seq_state, rclk_en); else pass_cnt++;
    step();
    total++; if (rclk_en !== 4'b0110) $display("FAIL mid_resync got %b want 0110", rclk_en); else pass_cnt++;
    repeat (6) step();
    total++; if (cluster_grst_l !== 4'b0000) $display("FAIL mid_e7 got %b want 0000", cluster_grst_l); else pass_cnt++;
    step();
    total++; if (cluster_grst_l !== 4'b0001) $display("FAIL mid_e8 got %b want 0001", cluster_grst_l); else pass_cnt++;
  endtask

  task automatic test_small();
    g2rst = 1'b1;
    step();
    total++; if (grst2_l !== 1'b0 || state2 !== 2'd0) $display("FAIL small_reset got %b/%0d want 0/0", grst2_l, state2); else pass_cnt++;
    g2rst = 1'b0;
    step();
    total++; if (grst2_l !== 1'b0 || state2 !== 2'd1) $display("FAIL small_e0 got %b/%0d want 0/1", grst2_l, state2); else pass_cnt++;
    step();
    total++; if (grst2_l !== 1'b1 || dbg2_l !== 1'b1) $display("FAIL small_rel got %b/%b want 1/1", grst2_l, dbg2_l); else pass_cnt++;
    total++; if (busy2 !== 1'b0 || state2 !== 2'd2) $display("FAIL small_run got %b/%0d want 0/2", busy2, state2); else pass_cnt++;
    req2 = 1'b1;
    step();
    req2 = 1'b0;
    total++; if (dbg2_l !== 1'b0 || state2 !== 2'd3) $display("FAIL small_dbg1 got %b/%0d want 0/3", dbg2_l, state2); else pass_cnt++;
    step();
    total++; if (dbg2_l !== 1'b0 || state2 !== 2'd1) $display("FAIL small_dbg2 got %b/%0d want 0/1", dbg2_l, state2); else pass_cnt++;
    step();
    total++; if (dbg2_l !== 1'b1 || state2 !== 2'd2 || grst2_l !== 1'b1) $display("FAIL small_dbg3 got %b/%0d/%b want 1/2/1", dbg2_l, state2, grst2_l); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_release();
    test_cken();
    test_dbg_pulse();
    test_dbg_held();
    test_grst_mid();
    test_small();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
